// File: rtl/cache_pkg.sv
// Shared types and geometry for the two-way write-through data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;
    localparam int INDEX_W   = 6;
    localparam int TAG_W     = 10;
    localparam int BLOCK_W   = 64;
    localparam int WORD_W    = 32;
    localparam int WSEL_BIT  = 2;
    localparam int INDEX_LSB = 3;
    localparam int TAG_LSB   = 9;

    // Controller states: IDLE, RD_MISS, WR
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t RD_MISS = 2'd1;
    localparam state_t WR      = 2'd2;

    // Pick the even (low) or odd (high) word of a block.
    function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                   input logic sel);
        return sel ? blk[BLOCK_W-1:WORD_W] : blk[WORD_W-1:0];
    endfunction
endpackage

// File: rtl/cache_controller_if.sv
// MEM-stage request bus plus SRAM-controller block/word access bus.
// Latency: n/a (wiring only).
// Backpressure: ready=0 freezes the pipeline; sram_ready ends each SRAM access.
interface cache_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [17:0] sram_addr;
    logic [31:0] sram_write_data;
    logic [63:0] sram_read_data;
    logic        sram_ready;

    modport slave (
        input  rd_en, wr_en, addr, write_data, sram_read_data, sram_ready,
        output read_data, ready, sram_rd_en, sram_wr_en, sram_addr, sram_write_data
    );

    modport master (
        output rd_en, wr_en, addr, write_data, sram_read_data, sram_ready,
        input  read_data, ready, sram_rd_en, sram_wr_en, sram_addr, sram_write_data
    );
endinterface

// File: rtl/cache_controller_way.sv
// One cache way: valid/tag/data arrays with combinational lookup, block fill and word write.
// Latency: lookup is combinational; fill and word write take effect on the next clk edge.
// Backpressure: none; the controller decides when fill/write strobes fire.
module cache_way #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index,
    input  logic [TAG_W-1:0]   tag,
    output logic               valid,
    output logic               hit,
    output logic [63:0]        data,
    input  logic               fill_en,
    input  logic [63:0]        fill_data,
    input  logic               wr_en,
    input  logic               wr_sel,
    input  logic [31:0]        wr_data
);
    import cache_pkg::*;

    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [BLOCK_W-1:0] data_q [SETS];

    assign valid = valid_q[index];
    assign hit   = valid_q[index] && (tag_q[index] == tag);
    assign data  = data_q[index];

    // Valid bits are the only state that must be cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
        end
    end

    // Tag/data storage: whole-block fill on a miss, or one word updated by a store hit
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[index]  <= tag;
            data_q[index] <= fill_data;
        end else if (wr_en) begin
            if (wr_sel) begin
                data_q[index][BLOCK_W-1:WORD_W] <= wr_data;
            end else begin
                data_q[index][WORD_W-1:0] <= wr_data;
            end
        end
    end
endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative write-through, no-write-allocate data cache for the MEM stage.
// Latency: read hit 0 cycles; read miss and store: 1 IDLE cycle + SRAM access (ready on sram_ready).
// Backpressure: ready=0 while an SRAM access is outstanding; pipeline holds its request meanwhile.
module cache_controller #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10
) (
    input  logic   clk,
    input  logic   rst,
    cache_if.slave bus
);
    import cache_pkg::*;

    localparam int SETS = 1 << INDEX_W;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               wsel;

    assign index = bus.addr[INDEX_LSB +: INDEX_W];
    assign tag   = bus.addr[TAG_LSB +: TAG_W];
    assign wsel  = bus.addr[WSEL_BIT];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[31:TAG_LSB+TAG_W], bus.addr[1:0]};

    state_t             state;
    logic [SETS-1:0]    lru;
    logic               v0, v1, h0, h1;
    logic [BLOCK_W-1:0] d0, d1;
    logic               any_hit, hit_way, victim;
    logic               read_hit, rd_done, wr_done;
    logic [WORD_W-1:0]  read_data_q, rd_word;
    logic               sram_rd_en_q, sram_wr_en_q;
    logic [17:0]        sram_addr_q;
    logic [WORD_W-1:0]  sram_wdata_q;
    logic               ready_c;

    assign any_hit  = h0 | h1;
    assign hit_way  = h1;
    // Prefer an empty way; only fall back to the LRU bit when both are valid
    assign victim   = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru[index]);
    assign read_hit = (state == IDLE) && bus.rd_en && !bus.wr_en && any_hit;
    assign rd_done  = (state == RD_MISS) && bus.sram_ready;
    assign wr_done  = (state == WR) && bus.sram_ready;

    cache_way #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way0 (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .tag       (tag),
        .valid     (v0),
        .hit       (h0),
        .data      (d0),
        .fill_en   (rd_done && !victim),
        .fill_data (bus.sram_read_data),
        .wr_en     (wr_done && h0),
        .wr_sel    (wsel),
        .wr_data   (bus.write_data)
    );

    cache_way #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way1 (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .tag       (tag),
        .valid     (v1),
        .hit       (h1),
        .data      (d1),
        .fill_en   (rd_done && victim),
        .fill_data (bus.sram_read_data),
        .wr_en     (wr_done && h1),
        .wr_sel    (wsel),
        .wr_data   (bus.write_data)
    );

    // Load data: hit word or fetched word this cycle, otherwise the last value returned
    always_comb begin
        rd_word = read_data_q;
        if (read_hit) begin
            rd_word = word_sel(hit_way ? d1 : d0, wsel);
        end else if (rd_done) begin
            rd_word = word_sel(bus.sram_read_data, wsel);
        end
    end

    // Pipeline freeze: low on a miss or store in IDLE, and while waiting on the SRAM
    always_comb begin
        ready_c = 1'b1;
        if (!rst) begin
            case (state)
                IDLE:    ready_c = !(bus.wr_en || (bus.rd_en && !any_hit));
                RD_MISS: ready_c = bus.sram_ready;
                WR:      ready_c = bus.sram_ready;
                default: ready_c = 1'b1;
            endcase
        end
    end

    assign bus.read_data       = rd_word;
    assign bus.ready           = ready_c;
    assign bus.sram_rd_en      = sram_rd_en_q;
    assign bus.sram_wr_en      = sram_wr_en_q;
    assign bus.sram_addr       = sram_addr_q;
    assign bus.sram_write_data = sram_wdata_q;

    // Hold register so read_data keeps its value between loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
        end else begin
            read_data_q <= rd_word;
        end
    end

    // LRU bit points at the way not touched by the latest hit, fill or store hit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru <= '0;
        end else if (read_hit) begin
            lru[index] <= ~hit_way;
        end else if (rd_done) begin
            lru[index] <= ~victim;
        end else if (wr_done && any_hit) begin
            lru[index] <= ~hit_way;
        end
    end

    // FSM with registered SRAM enables: they rise on entry and drop on the edge after sram_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sram_rd_en_q <= 1'b0;
            sram_wr_en_q <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wr_en) begin
                        state        <= WR;
                        sram_wr_en_q <= 1'b1;
                        sram_addr_q  <= bus.addr[TAG_LSB+TAG_W-1:1];
                        sram_wdata_q <= bus.write_data;
                    end else if (bus.rd_en && !any_hit) begin
                        state        <= RD_MISS;
                        sram_rd_en_q <= 1'b1;
                        sram_addr_q  <= {bus.addr[TAG_LSB+TAG_W-1:INDEX_LSB], 2'b00};
                    end
                end
                RD_MISS: begin
                    if (bus.sram_ready) begin
                        state        <= IDLE;
                        sram_rd_en_q <= 1'b0;
                    end
                end
                WR: begin
                    if (bus.sram_ready) begin
                        state        <= IDLE;
                        sram_wr_en_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    sram_rd_en_q <= 1'b0;
                    sram_wr_en_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: SRAM model with 6-cycle accesses plus an LRU-ordered tag model.
// Latency: expects 0-cycle read hits and ready on the 7th cycle of a miss or store.
// Backpressure: requests are held stable until ready returns high.
`timescale 1ns/1ps
module tb_cache_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_if bus();

    cache_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Memory image: serves SRAM reads and is the reference for expected load data
    logic [63:0] mem [0:65535];
    int unsigned sram_cnt;
    logic        sram_en;

    assign sram_en            = bus.sram_rd_en | bus.sram_wr_en;
    assign bus.sram_ready     = sram_en && (sram_cnt == 5);
    assign bus.sram_read_data = mem[bus.sram_addr[17:2]];

    always @(posedge clk) begin
        sram_cnt <= sram_en ? sram_cnt + 1 : 0;
    end

    // Reference: per set, the resident tags in recency order (most recent first)
    int          res_cnt [64];
    logic [9:0]  mru_tag [64];
    logic [9:0]  lru_tag [64];
    logic [31:0] last_rd;

    function automatic bit model_hit(input int s, input logic [9:0] t);
        return (res_cnt[s] >= 1 && mru_tag[s] == t) || (res_cnt[s] == 2 && lru_tag[s] == t);
    endfunction

    task automatic model_touch(input int s, input logic [9:0] t, input bit hit, input bit alloc);
        if (hit) begin
            if (res_cnt[s] == 2 && lru_tag[s] == t) begin
                lru_tag[s] = mru_tag[s];
                mru_tag[s] = t;
            end
        end else if (alloc) begin
            if (res_cnt[s] > 0) lru_tag[s] = mru_tag[s];
            mru_tag[s] = t;
            if (res_cnt[s] < 2) res_cnt[s] = res_cnt[s] + 1;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) res_cnt[i] = 0;
        last_rd = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One pipeline request, held until ready; optional idle cycle afterwards
    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd, input bit gap);
        int          s;
        logic [9:0]  t;
        logic [15:0] blk;
        bit          hit;
        logic [31:0] exp_word;
        logic [17:0] exp_saddr;
        int          cyc;
        int          en_cyc;
        logic        en_now;
        s         = int'(a[8:3]);
        t         = a[18:9];
        blk       = a[18:3];
        hit       = model_hit(s, t);
        exp_word  = a[2] ? mem[blk][63:32] : mem[blk][31:0];
        exp_saddr = wr ? a[18:1] : {a[18:3], 2'b00};

        @(negedge clk);
        bus.rd_en      = !wr;
        bus.wr_en      = wr;
        bus.addr       = a;
        bus.write_data = wd;
        #1;
        chk("idle_sram_en", {bus.sram_rd_en, bus.sram_wr_en}, 2'b00);
        if (!wr && hit) begin
            chk("hit_ready", bus.ready, 1'b1);
            chk("hit_data", bus.read_data, exp_word);
            last_rd = exp_word;
        end else begin
            chk("req_ready_low", bus.ready, 1'b0);
            cyc    = 1;
            en_cyc = 0;
            while (bus.ready !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                #1;
                cyc++;
                en_now = wr ? bus.sram_wr_en : bus.sram_rd_en;
                if (en_now === 1'b1) en_cyc++;
                if (cyc == 2) begin
                    chk("sram_addr", bus.sram_addr, exp_saddr);
                    if (wr) chk("sram_wdata", bus.sram_write_data, wd);
                end
            end
            chk("ready_cycle", cyc, 7);
            chk("sram_en_cycles", en_cyc, 6);
            if (!wr) begin
                chk("miss_data", bus.read_data, exp_word);
                last_rd = exp_word;
            end else begin
                chk("store_rd_hold", bus.read_data, last_rd);
            end
        end

        if (wr) begin
            if (a[2]) mem[blk][63:32] = wd;
            else      mem[blk][31:0]  = wd;
            model_touch(s, t, hit, 1'b0);
        end else begin
            model_touch(s, t, hit, 1'b1);
        end

        if (gap) begin
            @(negedge clk);
            bus.rd_en = 1'b0;
            bus.wr_en = 1'b0;
            #1;
            chk("gap_ready", bus.ready, 1'b1);
            chk("gap_sram_en", {bus.sram_rd_en, bus.sram_wr_en}, 2'b00);
            chk("gap_rd_hold", bus.read_data, last_rd);
        end
    endtask

    logic [31:0] rnd_a;
    logic [31:0] rnd_d;
    bit          rnd_wr;

    initial begin
        rst            = 1'b1;
        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.addr       = '0;
        bus.write_data = '0;
        for (int i = 0; i < 65536; i++) mem[i] = {$urandom, $urandom};
        mem[16'h0020] = 64'h1111_2222_3333_4444;
        model_clear();

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_read_data", bus.read_data, 32'h0);
        chk("rst_sram_en", {bus.sram_rd_en, bus.sram_wr_en}, 2'b00);
        chk("rst_sram_addr", bus.sram_addr, 18'h0);
        chk("rst_sram_wdata", bus.sram_write_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.ready, 1'b1);

        // Directed: cold miss, hit, eviction, store hit/miss
        access(1'b0, 32'h0000_0100, 32'h0, 1'b0);
        access(1'b0, 32'h0000_0104, 32'h0, 1'b1);
        chk("dir_hit_word", last_rd, 32'h1111_2222);
        access(1'b0, 32'h0000_0300, 32'h0, 1'b1);
        access(1'b0, 32'h0000_0100, 32'h0, 1'b1);
        access(1'b0, 32'h0000_0500, 32'h0, 1'b1);
        access(1'b0, 32'h0000_0300, 32'h0, 1'b1);
        access(1'b0, 32'h0000_0104, 32'h0, 1'b1);
        access(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 1'b1);
        access(1'b0, 32'h0000_0104, 32'h0, 1'b1);
        chk("dir_store_hit_word", last_rd, 32'hDEAD_BEEF);
        access(1'b1, 32'h0000_0200, 32'h0BAD_F00D, 1'b0);
        access(1'b0, 32'h0000_0200, 32'h0, 1'b1);

        // Reset during the third RD_MISS cycle
        @(negedge clk);
        bus.rd_en = 1'b1;
        bus.addr  = 32'h0000_1F00;
        #1;
        chk("rst_mid_req_ready", bus.ready, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mid_busy", bus.sram_rd_en, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_sram_rd_en", bus.sram_rd_en, 1'b0);
        chk("rst_mid_ready", bus.ready, 1'b1);
        chk("rst_mid_read_data", bus.read_data, 32'h0);
        @(negedge clk);
        bus.rd_en = 1'b0;
        rst       = 1'b0;
        model_clear();
        #1;
        chk("rst_mid_idle", {bus.ready, bus.sram_rd_en, bus.sram_wr_en}, 3'b100);
        access(1'b0, 32'h0000_0100, 32'h0, 1'b1);

        // Randomized traffic over a few conflicting sets and tags
        for (int n = 0; n < 150; n++) begin
            rnd_a       = $urandom;
            rnd_a[18:9] = 10'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       rnd_a[8:3] = 6'd0;
                1:       rnd_a[8:3] = 6'd1;
                default: rnd_a[8:3] = 6'd32;
            endcase
            rnd_d  = $urandom;
            rnd_wr = ($urandom_range(0, 9) < 3);
            access(rnd_wr, rnd_a, rnd_d, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
